// File: rtl/n1_pkg.sv
// Shared constants and types for the n1 program/data loader.
package n1_pkg;

  localparam int ADDR_W  = 8;
  localparam int PWORD_W = 16;
  localparam int DWORD_W = 8;

  localparam logic [7:0] CMD_RUN  = 8'hA0;
  localparam logic [7:0] CMD_PROG = 8'hA1;
  localparam logic [7:0] CMD_DATA = 8'hA2;
  localparam logic [7:0] CMD_HALT = 8'hA3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_ADDR = 3'd1,
    ST_GET_LEN  = 3'd2,
    ST_GET_LO   = 3'd3,
    ST_GET_HI   = 3'd4,
    ST_WRITE    = 3'd5
  } loader_state_e;

endpackage

// File: rtl/n1_prog_loader.sv
// Byte-serial loader: parses CMD/ADDR/LEN/payload frames from the pins and
// drives the program and data RAM write ports; also owns the core hold flag.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | waiting for a command byte (RUN/HALT handled in place)
// GET_ADDR    | next byte is the start address
// GET_LEN     | next byte is word count minus 1
// GET_LO      | next byte is the low byte (PROG) or the whole word (DATA)
// GET_HI      | next byte is the high byte of a program word
// WRITE       | one-cycle write strobe, then next word or back to IDLE
module n1_prog_loader
  import n1_pkg::*;
#(
  parameter int ADDR_W  = n1_pkg::ADDR_W,
  parameter int PWORD_W = n1_pkg::PWORD_W,
  parameter int DWORD_W = n1_pkg::DWORD_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               pram_we,
  output logic [ADDR_W-1:0]  pram_addr,
  output logic [PWORD_W-1:0] pram_wdata,
  output logic               dram_we,
  output logic [ADDR_W-1:0]  dram_addr,
  output logic [DWORD_W-1:0] dram_wdata,
  output logic               core_hold,
  output logic               load_done,
  output logic               err
);

  loader_state_e      state_q, state_d;
  logic               alive_q;
  logic               is_prog_q, is_prog_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic [7:0]         lo_q, lo_d;
  logic [ADDR_W-1:0]  pram_addr_q, pram_addr_d;
  logic [PWORD_W-1:0] pram_wdata_q, pram_wdata_d;
  logic [ADDR_W-1:0]  dram_addr_q, dram_addr_d;
  logic [DWORD_W-1:0] dram_wdata_q, dram_wdata_d;
  logic               hold_q, hold_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               xfer;

  // Handshake and strobes; the strobe exists only in WRITE while enabled,
  // and alive_q keeps in_ready low until the first edge after reset.
  always_comb begin
    in_ready = ena & alive_q & (state_q != ST_WRITE);
    xfer     = in_valid & in_ready;
    pram_we  = ena & (state_q == ST_WRITE) & is_prog_q;
    dram_we  = ena & (state_q == ST_WRITE) & ~is_prog_q;
  end

  // Next-state: frame parsing, word assembly and output register loading.
  // Write address/data outputs are latched on entry to WRITE so they stay
  // put afterwards while addr_q runs ahead.
  always_comb begin
    state_d      = state_q;
    is_prog_d    = is_prog_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    lo_d         = lo_q;
    pram_addr_d  = pram_addr_q;
    pram_wdata_d = pram_wdata_q;
    dram_addr_d  = dram_addr_q;
    dram_wdata_d = dram_wdata_q;
    hold_d       = hold_q;
    err_d        = err_q;
    done_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          case (in_data)
            CMD_RUN: begin
              hold_d = 1'b0;
              err_d  = 1'b0;
            end
            CMD_HALT: hold_d = 1'b1;
            CMD_PROG: begin
              is_prog_d = 1'b1;
              state_d   = ST_GET_ADDR;
            end
            CMD_DATA: begin
              is_prog_d = 1'b0;
              state_d   = ST_GET_ADDR;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      ST_GET_ADDR: begin
        if (xfer) begin
          addr_d  = in_data[ADDR_W-1:0];
          state_d = ST_GET_LEN;
        end
      end
      ST_GET_LEN: begin
        if (xfer) begin
          cnt_d   = in_data[ADDR_W-1:0];
          state_d = ST_GET_LO;
        end
      end
      ST_GET_LO: begin
        if (xfer) begin
          if (is_prog_q) begin
            lo_d    = in_data;
            state_d = ST_GET_HI;
          end else begin
            dram_addr_d  = addr_q;
            dram_wdata_d = in_data[DWORD_W-1:0];
            state_d      = ST_WRITE;
          end
        end
      end
      ST_GET_HI: begin
        if (xfer) begin
          pram_addr_d  = addr_q;
          pram_wdata_d = PWORD_W'({in_data, lo_q});
          state_d      = ST_WRITE;
        end
      end
      ST_WRITE: begin
        addr_d = addr_q + ADDR_W'(1);
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q - ADDR_W'(1);
          state_d = ST_GET_LO;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; ena low freezes everything except the post-reset flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      alive_q      <= 1'b0;
      is_prog_q    <= 1'b0;
      addr_q       <= '0;
      cnt_q        <= '0;
      lo_q         <= '0;
      pram_addr_q  <= '0;
      pram_wdata_q <= '0;
      dram_addr_q  <= '0;
      dram_wdata_q <= '0;
      hold_q       <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      alive_q <= 1'b1;
      if (ena) begin
        state_q      <= state_d;
        is_prog_q    <= is_prog_d;
        addr_q       <= addr_d;
        cnt_q        <= cnt_d;
        lo_q         <= lo_d;
        pram_addr_q  <= pram_addr_d;
        pram_wdata_q <= pram_wdata_d;
        dram_addr_q  <= dram_addr_d;
        dram_wdata_q <= dram_wdata_d;
        hold_q       <= hold_d;
        done_q       <= done_d;
        err_q        <= err_d;
      end
    end
  end

  assign pram_addr  = pram_addr_q;
  assign pram_wdata = pram_wdata_q;
  assign dram_addr  = dram_addr_q;
  assign dram_wdata = dram_wdata_q;
  assign core_hold  = hold_q;
  assign load_done  = done_q;
  assign err        = err_q;

endmodule
